dmem_arbiter: RTL and testbench

- Shares the single-port data memory between two requesters: port 0 is the CPU load/store path, port 1 is the program/data loader (DMA).
- At most one memory access is issued per cycle.
- Arbitration is round-robin, with optional locked bursts capped at BURST_MAX beats.
- Read data is registered and returned to the winning port one cycle after the access.
- A low m0_gnt while m0_req is high is the CPU stall condition.

---
 rtl/dmem_arbiter.sv | 177 +++++++++++++++++
 tb/tb_dmem_arbiter.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//   Shares one single-port data memory between two requesters:
//     port 0 = CPU load/store path, port 1 = program/data loader (DMA).
//   At most one access per cycle. Round-robin arbitration with optional
//   locked bursts of up to BURST_MAX beats. Read data is registered and
//   returned to the winning port one cycle after the access.
//   A low m0_gnt while m0_req is high stalls the CPU.
//
// Configuration macro:
//   DMEM_ARB_FIXED_PRIO_EN  when defined, port 0 always wins a contest in
//                           IDLE (last-granted history is ignored). Locks
//                           and the burst cap behave identically.
//
// Ports:
//   clk, reset            clock, asynchronous active-low reset
//   mX_req/we/lock        port X request, write enable, keep-ownership hint
//   mX_addr/wdata         port X byte address and write data
//   mX_gnt                port X transfer accepted this cycle
//   mX_rvalid/rdata       port X read response (one cycle after the read)
//   mem_re/we             memory read / write strobes
//   mem_addr/wdata        memory address and write data (winner's, else 0)
//   mem_rdata             memory read data, combinational from mem_addr
// -----------------------------------------------------------------------------
module dmem_arbiter #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned BURST_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic              m0_lock,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic              m1_lock,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              mem_re,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_e;

  localparam logic [4:0] BURST_MAX_W = 5'(BURST_MAX);

  state_e            state_q, state_d;
  logic              last_q, last_d;
  logic [3:0]        beat_q, beat_d;
  logic              resp_v_q, resp_v_d;
  logic              resp_id_q, resp_id_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;

  logic       gnt0, gnt1, xfer, win, win_we, win_lock;
  logic [4:0] beat_inc;

  // NOTE: every signal written here gets a default first, so no path
  // through the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    state_d   = state_q;
    last_d    = last_q;
    beat_d    = beat_q;

    unique case (state_q)
      IDLE: begin
        if (m0_req && m1_req) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
          gnt0 = 1'b1;
`else
          // Round-robin: the port that did not win last time goes first.
          if (last_q) gnt0 = 1'b1;
          else        gnt1 = 1'b1;
`endif
        end else begin
          gnt0 = m0_req;
          gnt1 = m1_req;
        end
      end
      OWN0: begin
        if (m0_req) gnt0 = 1'b1;
        else begin
          state_d = IDLE;
          beat_d  = '0;
        end
      end
      OWN1: begin
        if (m1_req) gnt1 = 1'b1;
        else begin
          state_d = IDLE;
          beat_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        beat_d  = '0;
      end
    endcase

    // Nothing is granted while reset is held, regardless of requests.
    gnt0     = gnt0 & reset;
    gnt1     = gnt1 & reset;
    xfer     = gnt0 | gnt1;
    win      = gnt1;
    win_we   = win ? m1_we   : m0_we;
    win_lock = win ? m1_lock : m0_lock;
    beat_inc = {1'b0, beat_q} + 5'd1;

    if (xfer) begin
      last_d = win;
      // Keep ownership only while the lock is asserted and the cap is not
      // reached; hitting the cap forces a release back to arbitration.
      if (win_lock && (beat_inc < BURST_MAX_W)) begin
        state_d = win ? OWN1 : OWN0;
        beat_d  = beat_inc[3:0];
      end else begin
        state_d = IDLE;
        beat_d  = '0;
      end
    end

    resp_v_d  = xfer & ~win_we;
    resp_id_d = resp_id_q;
    rdata_d   = rdata_q;
    if (resp_v_d) begin
      resp_id_d = win;
      rdata_d   = mem_rdata;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      beat_q    <= '0;
      resp_v_q  <= 1'b0;
      resp_id_q <= 1'b0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      beat_q    <= beat_d;
      resp_v_q  <= resp_v_d;
      resp_id_q <= resp_id_d;
      rdata_q   <= rdata_d;
    end
  end

  assign m0_gnt    = gnt0;
  assign m1_gnt    = gnt1;
  assign mem_we    = xfer & win_we;
  assign mem_re    = xfer & ~win_we;
  assign mem_addr  = xfer ? (win ? m1_addr  : m0_addr)  : '0;
  assign mem_wdata = xfer ? (win ? m1_wdata : m0_wdata) : '0;

  // The response register never stalls; the non-responding port sees zero.
  assign m0_rvalid = resp_v_q & ~resp_id_q;
  assign m1_rvalid = resp_v_q &  resp_id_q;
  assign m0_rdata  = m0_rvalid ? rdata_q : '0;
  assign m1_rdata  = m1_rvalid ? rdata_q : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//   Directed scenarios plus a randomized run against a behavioural model of
//   the arbitration rules (owner / beat count / last winner / response slot)
//   and an independent shadow copy of the memory.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int BM = 4;

  logic          clk   = 1'b0;
  logic          reset = 1'b0;
  logic          m0_req, m0_we, m0_lock, m0_gnt, m0_rvalid;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_we, m1_lock, m1_gnt, m1_rvalid;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          mem_re, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;

  logic [DW-1:0] mem_arr [64] = '{default: '0};

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign mem_rdata = mem_re ? mem_arr[mem_addr[7:2]] : '0;
  always @(posedge clk) if (mem_we) mem_arr[mem_addr[7:2]] <= mem_wdata;

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .BURST_MAX(BM)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_lock(m0_lock), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_lock(m1_lock), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
    .mem_re(mem_re), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  task automatic drive(input int p, input bit req, input bit we, input bit lock,
                       input logic [31:0] addr, input logic [31:0] wdata);
    if (p == 0) begin
      m0_req = req; m0_we = we; m0_lock = lock; m0_addr = addr; m0_wdata = wdata;
    end else begin
      m1_req = req; m1_we = we; m1_lock = lock; m1_addr = addr; m1_wdata = wdata;
    end
  endtask

  task automatic idle_all();
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    #2 reset = 1'b1;
  endtask

  task automatic test_reset();
    drive(0, 1, 0, 1, 32'h10, 32'hA5A5_0001);
    drive(1, 1, 1, 1, 32'h20, 32'hA5A5_0002);
    @(negedge clk);
    n_checks++;
    if ({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_re, mem_we} !== 6'b0)
      $display("FAIL rst_flags: got %b expected %b",
               {m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, mem_re, mem_we}, 6'b0);
    else n_pass++;
    n_checks++;
    if ({mem_addr, mem_wdata, m0_rdata, m1_rdata} !== 128'h0)
      $display("FAIL rst_buses: got %h expected 0", {mem_addr, mem_wdata, m0_rdata, m1_rdata});
    else n_pass++;
    drive(0, 1, 0, 0, 32'h10, 0);
    drive(1, 1, 0, 0, 32'h20, 0);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10)
      $display("FAIL rst_first_gnt: got %b expected %b", {m0_gnt, m1_gnt}, 2'b10);
    else n_pass++;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
`ifdef DMEM_ARB_FIXED_PRIO_EN
    if ({m0_gnt, m1_gnt} !== 2'b10)
      $display("FAIL rst_second_gnt: got %b expected %b", {m0_gnt, m1_gnt}, 2'b10);
    else n_pass++;
`else
    if ({m0_gnt, m1_gnt} !== 2'b01)
      $display("FAIL rst_second_gnt: got %b expected %b", {m0_gnt, m1_gnt}, 2'b01);
    else n_pass++;
`endif
    @(posedge clk);
    #1 idle_all();
  endtask

  task automatic test_write_read();
    drive(1, 1, 1, 0, 32'h40, 32'hDEAD_BEEF);
    @(negedge clk);
    n_checks++;
    if ({m1_gnt, mem_we, mem_re, mem_addr} !== {3'b110, 32'h40})
      $display("FAIL wr_issue: got %h expected %h", {m1_gnt, mem_we, mem_re, mem_addr}, {3'b110, 32'h40});
    else n_pass++;
    @(posedge clk);
    #1;
    drive(1, 0, 0, 0, 0, 0);
    drive(0, 1, 0, 0, 32'h40, 0);
    @(negedge clk);
    n_checks++;
    if ({m0_gnt, mem_re, mem_we} !== 3'b110)
      $display("FAIL rd_issue: got %b expected %b", {m0_gnt, mem_re, mem_we}, 3'b110);
    else n_pass++;
    @(posedge clk);
    #1 idle_all();
    @(negedge clk);
    n_checks++;
    if ({m0_rvalid, m1_rvalid} !== 2'b10)
      $display("FAIL rd_rvalid: got %b expected %b", {m0_rvalid, m1_rvalid}, 2'b10);
    else n_pass++;
    n_checks++;
    if (m0_rdata !== 32'hDEAD_BEEF)
      $display("FAIL rd_data: got %h expected %h", m0_rdata, 32'hDEAD_BEEF);
    else n_pass++;
    n_checks++;
    if (m1_rdata !== 32'h0)
      $display("FAIL rd_other_port: got %h expected %h", m1_rdata, 32'h0);
    else n_pass++;
    @(posedge clk);
    #1;
    @(negedge clk);
    n_checks++;
    if (m0_rvalid !== 1'b0)
      $display("FAIL rd_pulse: got %b expected %b", m0_rvalid, 1'b0);
    else n_pass++;
    @(posedge clk);
    #1;
  endtask

  // Entered with port 0 as last winner, so a contest favours port 1.
  task automatic test_burst_cap();
    logic [1:0] exp;
    drive(1, 1, 0, 1, 32'h80, 0);
`ifdef DMEM_ARB_FIXED_PRIO_EN
    drive(0, 0, 0, 0, 0, 0);
`else
    drive(0, 1, 0, 0, 32'h84, 0);
`endif
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      exp = (c < 4) ? 2'b01 : 2'b10;
      n_checks++;
      if ({m0_gnt, m1_gnt} !== exp)
        $display("FAIL burst_gnt_c%0d: got %b expected %b", c, {m0_gnt, m1_gnt}, exp);
      else n_pass++;
      if (c >= 1) begin
        n_checks++;
        if (m1_rvalid !== 1'b1)
          $display("FAIL burst_rvalid_c%0d: got %b expected %b", c, m1_rvalid, 1'b1);
        else n_pass++;
      end
      @(posedge clk);
      #1 drive(0, 1, 0, 0, 32'h84, 0);
    end
    idle_all();
    @(posedge clk);
    #1;
  endtask

  task automatic test_lock_drop();
    logic [1:0] exp;
    drive(1, 1, 1, 0, 32'h100, 32'h11);
    @(posedge clk);
    #1;
    drive(0, 1, 0, 1, 32'h44, 0);
    drive(1, 1, 0, 0, 32'h48, 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      exp = (c < 2) ? 2'b10 : (c == 2) ? 2'b00 : 2'b01;
      n_checks++;
      if ({m0_gnt, m1_gnt} !== exp)
        $display("FAIL drop_gnt_c%0d: got %b expected %b", c, {m0_gnt, m1_gnt}, exp);
      else n_pass++;
      @(posedge clk);
      #1;
      if (c == 1) drive(0, 0, 0, 0, 0, 0);
    end
    idle_all();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_read();
    drive(0, 1, 0, 0, 32'h40, 0);
    @(negedge clk);
    n_checks++;
    if (m0_gnt !== 1'b1)
      $display("FAIL midrst_issue: got %b expected %b", m0_gnt, 1'b1);
    else n_pass++;
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    n_checks++;
    if ({m0_gnt, m0_rvalid} !== 2'b00)
      $display("FAIL midrst_held: got %b expected %b", {m0_gnt, m0_rvalid}, 2'b00);
    else n_pass++;
    #1 reset = 1'b1;
    drive(1, 1, 0, 0, 32'h48, 0);
    @(negedge clk);
    n_checks++;
    if (m0_rvalid !== 1'b0)
      $display("FAIL midrst_no_rvalid: got %b expected %b", m0_rvalid, 1'b0);
    else n_pass++;
    n_checks++;
    if ({m0_gnt, m1_gnt} !== 2'b10)
      $display("FAIL midrst_first_gnt: got %b expected %b", {m0_gnt, m1_gnt}, 2'b10);
    else n_pass++;
    @(posedge clk);
    #1 idle_all();
  endtask

  task automatic test_contention();
    logic [1:0] exp;
    pulse_reset();
    drive(0, 1, 0, 0, 32'h4, 0);
    drive(1, 1, 0, 0, 32'h8, 0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
`ifdef DMEM_ARB_FIXED_PRIO_EN
      exp = 2'b10;
`else
      exp = (c % 2 == 0) ? 2'b10 : 2'b01;
`endif
      n_checks++;
      if ({m0_gnt, m1_gnt} !== exp)
        $display("FAIL contend_c%0d: got %b expected %b", c, {m0_gnt, m1_gnt}, exp);
      else n_pass++;
      @(posedge clk);
      #1;
    end
    idle_all();
  endtask

  task automatic rand_txn(output bit r, output bit w, output bit l,
                          output logic [31:0] a, output logic [31:0] d);
    r = ($urandom_range(3) != 0);
    w = 1'($urandom_range(1));
    l = 1'($urandom_range(1));
    a = 32'($urandom_range(15)) << 2;
    d = $urandom;
  endtask

  task automatic test_random();
    bit            rq[2], wq[2], lk[2];
    logic [31:0]   ad[2], wd[2];
    logic [31:0]   ref_mem[64];
    int            own, beats, ew, idx;
    bit            last, rv, rid;
    logic [31:0]   rd;
    logic [1:0]    eg, es, erv;
    logic [63:0]   erd;
    for (int i = 0; i < 64; i++) ref_mem[i] = mem_arr[i];
    idle_all();
    pulse_reset();
    own = -1; beats = 0; last = 1'b1; rv = 1'b0; rid = 1'b0; rd = '0;
    for (int p = 0; p < 2; p++) rand_txn(rq[p], wq[p], lk[p], ad[p], wd[p]);
    for (int cyc = 0; cyc < 400; cyc++) begin
      for (int p = 0; p < 2; p++) drive(p, rq[p], wq[p], lk[p], ad[p], wd[p]);
      @(negedge clk);
      ew = -1;
      if (own < 0) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        if (rq[0] && rq[1]) ew = 0;
`else
        if (rq[0] && rq[1]) ew = last ? 0 : 1;
`endif
        else if (rq[0]) ew = 0;
        else if (rq[1]) ew = 1;
      end else if (rq[own]) ew = own;
      eg  = (ew == 0) ? 2'b10 : (ew == 1) ? 2'b01 : 2'b00;
      es  = (ew >= 0) ? {wq[ew], !wq[ew]} : 2'b00;
      erv = rv ? (rid ? 2'b01 : 2'b10) : 2'b00;
      erd = rv ? (rid ? {32'h0, rd} : {rd, 32'h0}) : 64'h0;
      n_checks++;
      if ({m0_gnt, m1_gnt} !== eg)
        $display("FAIL rnd_gnt_%0d: got %b expected %b", cyc, {m0_gnt, m1_gnt}, eg);
      else n_pass++;
      n_checks++;
      if ({mem_we, mem_re} !== es)
        $display("FAIL rnd_strobe_%0d: got %b expected %b", cyc, {mem_we, mem_re}, es);
      else n_pass++;
      if (ew >= 0) begin
        n_checks++;
        if (mem_addr !== ad[ew])
          $display("FAIL rnd_addr_%0d: got %h expected %h", cyc, mem_addr, ad[ew]);
        else n_pass++;
      end
      n_checks++;
      if ({m0_rvalid, m1_rvalid} !== erv)
        $display("FAIL rnd_rvalid_%0d: got %b expected %b", cyc, {m0_rvalid, m1_rvalid}, erv);
      else n_pass++;
      n_checks++;
      if ({m0_rdata, m1_rdata} !== erd)
        $display("FAIL rnd_rdata_%0d: got %h expected %h", cyc, {m0_rdata, m1_rdata}, erd);
      else n_pass++;
      @(posedge clk);
      if (own >= 0 && !rq[own]) begin
        own = -1; beats = 0;
      end
      rv = 1'b0;
      if (ew >= 0) begin
        idx  = int'(ad[ew][7:2]);
        last = ew[0];
        if (wq[ew]) ref_mem[idx] = wd[ew];
        else begin
          rv = 1'b1; rid = ew[0]; rd = ref_mem[idx];
        end
        if (lk[ew]) begin
          beats++;
          if (beats < BM) own = ew;
          else begin own = -1; beats = 0; end
        end else begin
          own = -1; beats = 0;
        end
      end
      #1;
      for (int p = 0; p < 2; p++)
        if (ew == p || !rq[p]) rand_txn(rq[p], wq[p], lk[p], ad[p], wd[p]);
    end
    idle_all();
  endtask

  initial begin
    idle_all();
    test_reset();
    test_write_read();
    test_burst_cap();
    test_lock_drop();
    test_reset_mid_read();
    test_contention();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
